// File: rtl/pc_sequencer_if.sv
// Bus bundle between the decoder/ALU side and pc_sequencer: control, branch flags,
// target-LUT write port, sequencer outputs and a debug view of the FSM state.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
);
  logic             start;
  logic             halt;
  logic [2:0]       br_op;
  logic [LUT_W-1:0] tgt_idx;
  logic             beq;
  logic             slt;
  logic             lut_we;
  logic [LUT_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             busy;
  logic             done;
  logic             stack_err;
  logic [1:0]       dbg_state;

  modport master (
    output start, halt, br_op, tgt_idx, beq, slt, lut_we, lut_waddr, lut_wdata,
    input  prog_ctr, busy, done, stack_err, dbg_state
  );

  modport slave (
    input  start, halt, br_op, tgt_idx, beq, slt, lut_we, lut_waddr, lut_wdata,
    output prog_ctr, busy, done, stack_err, dbg_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / branch sequencer with a writable branch-target LUT.
// Define PC_RET_STACK_EN to add the call/return stack; otherwise call = jmp, ret = none.
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int LUT_W       = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int LUT_N = 1 << LUT_W;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_inc, w_tgt;
  logic             r_busy, r_done;
  logic             w_restart;
  logic [PC_W-1:0]  r_lut [LUT_N];

  assign w_pc_inc = r_pc + 1'b1;
  assign w_tgt    = r_lut[bus.tgt_idx];

`ifdef PC_RET_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  r_stack [STACK_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic             r_err;
  logic             w_push, w_pop, w_full, w_empty;
  logic [IDX_W-1:0] w_top_idx, w_push_idx;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_top_idx  = IDX_W'(r_sp - 1'b1);
  assign w_push_idx = IDX_W'(r_sp);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_restart   = 1'b0;
`ifdef PC_RET_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_restart   = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.start) begin
          w_pc_nxt  = '0;
          w_restart = 1'b1;
        end else if (bus.halt) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pc_nxt = w_pc_inc;
          case (bus.br_op)
            3'b001: if (bus.beq)  w_pc_nxt = w_tgt;
            3'b010: if (!bus.beq) w_pc_nxt = w_tgt;
            3'b011: if (bus.slt)  w_pc_nxt = w_tgt;
            3'b100: w_pc_nxt = w_tgt;
            3'b101: begin
              // Jump is taken even when the push is dropped on a full stack.
              w_pc_nxt = w_tgt;
`ifdef PC_RET_STACK_EN
              w_push   = 1'b1;
`endif
            end
            3'b110: begin
`ifdef PC_RET_STACK_EN
              w_pop = 1'b1;
              if (!w_empty) w_pc_nxt = r_stack[w_top_idx];
`endif
            end
            default: ;
          endcase
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Reads see the pre-write contents because the table is a plain register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
    end else if (bus.lut_we) begin
      r_lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

`ifdef PC_RET_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else if (w_restart) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else if (w_push) begin
      if (w_full) r_err <= 1'b1;
      else        r_sp  <= r_sp + 1'b1;
    end else if (w_pop) begin
      if (w_empty) r_err <= 1'b1;
      else         r_sp  <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_full) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign bus.stack_err = r_err;
`else
  // No stack present: the error flag is a constant zero (depth only sizes the optional stack).
  localparam logic NO_STACK_ERR = (STACK_DEPTH < 0);
  assign bus.stack_err = NO_STACK_ERR;
`endif

  assign bus.prog_ctr  = r_pc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue/array reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   chk_en   = 0;

  pc_sequencer_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int              m_mode = M_IDLE;
  logic [PC_W-1:0] m_pc   = '0;
  bit              m_err  = 0;
  logic [PC_W-1:0] m_lut [2**LUT_W];
  logic [PC_W-1:0] m_stk [$];

  always @(posedge clk or negedge rst_n) begin
    logic [PC_W-1:0] tgt, seq;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_pc   = '0;
      m_err  = 0;
      m_stk.delete();
      for (int i = 0; i < 2**LUT_W; i++) m_lut[i] = '0;
    end else begin
      tgt = m_lut[bus.tgt_idx];
      seq = m_pc + 10'd1;
      if (bus.start) begin
        m_mode = M_RUN;
        m_pc   = '0;
        m_err  = 0;
        m_stk.delete();
      end else if (m_mode == M_RUN) begin
        if (bus.halt) m_mode = M_DONE;
        else begin
          case (bus.br_op)
            3'd1: m_pc = bus.beq  ? tgt : seq;
            3'd2: m_pc = !bus.beq ? tgt : seq;
            3'd3: m_pc = bus.slt  ? tgt : seq;
            3'd4: m_pc = tgt;
`ifdef PC_RET_STACK_EN
            3'd5: begin
              if (m_stk.size() >= DEPTH) m_err = 1;
              else m_stk.push_back(seq);
              m_pc = tgt;
            end
            3'd6: begin
              if (m_stk.size() == 0) begin m_err = 1; m_pc = seq; end
              else m_pc = m_stk.pop_back();
            end
`else
            3'd5: m_pc = tgt;
`endif
            default: m_pc = seq;
          endcase
        end
      end
      if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc",   32'(bus.prog_ctr), 32'(m_pc));
      check("model_busy", 32'(bus.busy),     32'(m_mode == M_RUN));
      check("model_done", 32'(bus.done),     32'(m_mode == M_DONE));
      check("model_err",  32'(bus.stack_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.halt = 0; bus.br_op = 3'd0; bus.tgt_idx = '0;
    bus.beq = 0; bus.slt = 0; bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  task automatic do_start();
    bus.start = 1; cyc(); bus.start = 0;
  endtask

  task automatic branch(input logic [2:0] op, input logic [LUT_W-1:0] idx,
                        input logic beqv, input logic sltv);
    bus.br_op = op; bus.tgt_idx = idx; bus.beq = beqv; bus.slt = sltv;
    cyc();
    bus.br_op = 3'd0; bus.beq = 0; bus.slt = 0;
  endtask

  task automatic lut_write(input logic [LUT_W-1:0] a, input logic [PC_W-1:0] d);
    bus.lut_we = 1; bus.lut_waddr = a; bus.lut_wdata = d;
    cyc();
    bus.lut_we = 0;
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic b, input logic d,
                     input logic e);
    check({name, "_pc"},   32'(bus.prog_ctr),  pc);
    check({name, "_busy"}, 32'(bus.busy),      32'(b));
    check({name, "_done"}, 32'(bus.done),      32'(d));
    check({name, "_err"},  32'(bus.stack_err), 32'(e));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1 rst_n = 1'b0;
    #1 chk_en = 1;
    cyc(2);
    lit("reset", 32'h0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    lit("idle_hold", 32'h0, 0, 0, 0);

    do_start();
    lit("start", 32'h0, 1, 0, 0);
    cyc(5);
    lit("seq5", 32'h5, 1, 0, 0);

    lut_write(5'd3, 10'h120);
    lut_write(5'd1, 10'h040);

    do_start(); cyc(2);
    branch(3'd1, 5'd3, 1, 0);
    lit("beq_taken", 32'h120, 1, 0, 0);
    do_start(); cyc(2);
    branch(3'd1, 5'd3, 0, 0);
    lit("beq_not", 32'h3, 1, 0, 0);
    branch(3'd3, 5'd3, 0, 1);
    lit("blt_taken", 32'h120, 1, 0, 0);
    branch(3'd2, 5'd3, 1, 0);
    lit("bne_not", 32'h121, 1, 0, 0);
    branch(3'd7, 5'd3, 1, 1);
    lit("reserved", 32'h122, 1, 0, 0);

    // Write and read LUT[4] in the same cycle: the jump must use the old (zero) entry.
    bus.lut_we = 1; bus.lut_waddr = 5'd4; bus.lut_wdata = 10'h200;
    branch(3'd4, 5'd4, 0, 0);
    bus.lut_we = 0;
    lit("lut_old", 32'h0, 1, 0, 0);
    branch(3'd4, 5'd4, 0, 0);
    lit("lut_new", 32'h200, 1, 0, 0);

    do_start(); cyc(7);
    bus.halt = 1;
    branch(3'd4, 5'd3, 0, 0);
    bus.halt = 0;
    lit("halt", 32'h7, 0, 1, 0);
    cyc(2);
    lit("done_hold", 32'h7, 0, 1, 0);
    do_start();
    lit("restart", 32'h0, 1, 0, 0);

    cyc(1023);
    lit("pc_max", 32'h3FF, 1, 0, 0);
    cyc();
    lit("wrap", 32'h0, 1, 0, 0);

    do_start(); cyc(5);
    branch(3'd5, 5'd1, 0, 0);
    lit("call", 32'h40, 1, 0, 0);
    branch(3'd6, 5'd0, 0, 0);
`ifdef PC_RET_STACK_EN
    lit("ret", 32'h6, 1, 0, 0);
    do_start();
    for (int i = 0; i < 4; i++) branch(3'd5, 5'd1, 0, 0);
    lit("call4", 32'h40, 1, 0, 0);
    branch(3'd5, 5'd1, 0, 0);
    lit("call5_ovf", 32'h40, 1, 0, 1);
    branch(3'd6, 5'd0, 0, 0);
    lit("ret_after_ovf", 32'h41, 1, 0, 1);
    do_start();
    lit("start_clr_err", 32'h0, 1, 0, 0);
    cyc(2);
    branch(3'd6, 5'd0, 0, 0);
    lit("ret_empty", 32'h3, 1, 0, 1);
`else
    lit("ret_as_none", 32'h41, 1, 0, 0);
`endif

    do_start(); cyc(32'h55);
    lit("pre_reset", 32'h55, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    lit("async_reset", 32'h0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    do_start();
    branch(3'd4, 5'd3, 0, 0);
    lit("lut_cleared", 32'h0, 1, 0, 0);
    cyc(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
